// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then streams header, payload and parity with busy back-pressure.
// Optional parity-error injection via inj_err_i when ROUTER_PKT_TX_PARITY_INJ_EN is defined.
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int IFG_CYCLES = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    input  logic       inj_err_i,
`endif
    input  logic       start_i,
    input  logic [1:0] addr_i,
    input  logic [5:0] len_i,
    output logic       cmd_ready_o,
    output logic       cmd_err_o,
    input  logic [7:0] pl_data_i,
    input  logic       pl_valid_i,
    output logic       pl_ready_o,
    input  logic       busy_i,
    output logic       pkt_valid_o,
    output logic [7:0] data_out_o,
    output logic       tx_done_o
);

    // states: IDLE wait cmd | LOAD fill buffer | HDR header | PAY payload | PAR parity | GAP inter-frame gap
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAY,
        S_PAR,
        S_GAP
    } state_t;

    localparam int GAP_W = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       wr_ptr_q, wr_ptr_d;
    logic [5:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]       parity_q, parity_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             cmd_err_q, cmd_err_d;
    logic             tx_done_q, tx_done_d;

    logic [7:0]       mem_q [MAX_LEN];

    logic             cmd_ok;
    logic             inj_bit;
    logic [5:0]       last_idx;
    logic [5:0]       rd_nxt;
    logic [7:0]       par_nxt;

    assign cmd_ok   = (addr_i != 2'd3) && (len_i != 6'd0);
    assign last_idx = len_q - 6'd1;
    assign rd_nxt   = rd_ptr_q + 6'd1;
    assign par_nxt  = parity_q ^ data_out_q;

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic inj_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            inj_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i && cmd_ok) begin
            inj_q <= inj_err_i;
        end
    end

    assign inj_bit = inj_q;
`else
    assign inj_bit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        parity_d    = parity_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_valid_d = pkt_valid_q;
        data_out_d  = data_out_q;
        cmd_err_d   = 1'b0;
        tx_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                pkt_valid_d = 1'b0;
                data_out_d  = 8'h00;
                if (start_i) begin
                    if (cmd_ok) begin
                        addr_d   = addr_i;
                        len_d    = len_i;
                        wr_ptr_d = 6'd0;
                        state_d  = S_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (pl_valid_i) begin
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == last_idx) begin
                        state_d     = S_HDR;
                        pkt_valid_d = 1'b1;
                        data_out_d  = {len_q, addr_q};
                    end
                end
            end

            S_HDR: begin
                if (!busy_i) begin
                    parity_d   = data_out_q;
                    rd_ptr_d   = 6'd0;
                    data_out_d = mem_q[0];
                    state_d    = S_PAY;
                end
            end

            // data_out_q always holds the byte being offered, so parity folds it in on acceptance
            S_PAY: begin
                if (!busy_i) begin
                    parity_d = par_nxt;
                    if (rd_ptr_q == last_idx) begin
                        state_d     = S_PAR;
                        pkt_valid_d = 1'b0;
                        data_out_d  = par_nxt ^ {7'b0, inj_bit};
                    end else begin
                        rd_ptr_d   = rd_nxt;
                        data_out_d = mem_q[rd_nxt];
                    end
                end
            end

            S_PAR: begin
                if (!busy_i) begin
                    tx_done_d   = 1'b1;
                    pkt_valid_d = 1'b0;
                    data_out_d  = 8'h00;
                    parity_d    = 8'h00;
                    rd_ptr_d    = 6'd0;
                    wr_ptr_d    = 6'd0;
                    if (IFG_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                pkt_valid_d = 1'b0;
                data_out_d  = 8'h00;
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                pkt_valid_d = 1'b0;
                data_out_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wr_ptr_q    <= 6'd0;
            rd_ptr_q    <= 6'd0;
            parity_q    <= 8'h00;
            gap_cnt_q   <= '0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= 8'h00;
            cmd_err_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            parity_q    <= parity_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            cmd_err_q   <= cmd_err_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Payload storage carries no reset; stale contents are never read before being rewritten
    always_ff @(posedge clock_i) begin
        if (state_q == S_LOAD && pl_valid_i) begin
            mem_q[wr_ptr_q] <= pl_data_i;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign pl_ready_o  = (state_q == S_LOAD);
    assign cmd_err_o   = cmd_err_q;
    assign tx_done_o   = tx_done_q;
    assign pkt_valid_o = pkt_valid_q;
    assign data_out_o  = data_out_q;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter that drives the router input port (pkt_valid / 8-bit data) in the router packet format.
- Format: header byte = {len[5:0], addr[1:0]}, then len payload bytes with pkt_valid high, then one parity byte with pkt_valid low.
- Parity = XOR of the header and all payload bytes.
- The block buffers a whole payload before sending, so there are never bubbles inside a packet. It honours the router's busy back-pressure.

Parameters:
MAX_LEN, 63, largest payload length; sets buffer depth (len field is 6 bits).
IFG_CYCLES, 2, minimum idle cycles after the parity byte before the next command is accepted (0 allowed).

Ports:
clock      input   1  single clock; all logic on posedge
reset      input   1  synchronous, active-high reset
start      input   1  command strobe; sampled only in IDLE
addr       input   2  destination port 0..2; 3 is illegal
len        input   6  payload length 1..63; 0 is illegal
cmd_ready  output  1  high exactly while in IDLE
cmd_err    output  1  one-cycle pulse when an illegal command is rejected
pl_data    input   8  payload byte
pl_valid   input   1  payload byte valid
pl_ready   output  1  high exactly while in LOAD
busy       input   1  router back-pressure; high stalls the output byte
pkt_valid  output  1  high during header and payload bytes
data_out   output  8  byte to router
tx_done    output  1  one-cycle pulse on entry to GAP

Behaviour:
- Reset (any state, mid-packet included) forces the following on the next edge:
  - state IDLE;
  - pkt_valid=0, data_out=0, cmd_err=0, tx_done=0;
  - all counters and the parity accumulator cleared.
  - Buffer contents are don't-care.
- pkt_valid and data_out are registered. There is no combinational path from busy to either.
- Byte acceptance: an output byte is consumed on an edge where the state is HDR, PAY or PAR and busy=0.
  - While busy=1, data_out and pkt_valid hold their current values.
  - No byte is duplicated or skipped.
- IDLE: pkt_valid=0, data_out=0.
  - start with addr!=3 and len!=0: latch addr/len, clear the write pointer, go to LOAD.
  - start with addr==3 or len==0: cmd_err pulses one cycle, stay in IDLE.
- LOAD:
  - Each edge with pl_valid&pl_ready writes pl_data to buf[wr_ptr] and increments wr_ptr.
  - On acceptance of the len-th byte, go to HDR. pl_ready is low from the next cycle.
  - pl_valid gaps are allowed; nothing is driven to the router during LOAD.
- HDR: data_out={len,addr}, pkt_valid=1. This begins the cycle after the last payload byte is accepted. On acceptance: parity=header, rd_ptr=0, go to PAY.
- PAY: data_out=buf[rd_ptr], pkt_valid=1.
  - On acceptance: parity^=byte, rd_ptr++.
  - After the len-th byte, go to PAR; the next byte is presented with no idle cycle.
- PAR: data_out=parity, pkt_valid=0. On acceptance, go to GAP.
- GAP: tx_done=1 in the first GAP cycle. pkt_valid=0, data_out=0 for IFG_CYCLES cycles, then IDLE.
  - With IFG_CYCLES=0, PAR goes directly to IDLE and tx_done still pulses for one cycle.
- Simultaneous events:
  - start outside IDLE is ignored, with no cmd_err.
  - busy is ignored in IDLE, LOAD and GAP.
  - pl_valid is ignored outside LOAD.
- Width: the parity accumulator is 8 bits. Counters are 6 bits with no wrap; len ≤ 63 is guaranteed by the port width.

Optional Feature:
Macro: ROUTER_PKT_TX_PARITY_INJ_EN.
- Defined: adds input inj_err (1 bit), sampled with an accepted start. If it was 1, the PAR byte is sent as parity^8'h01, exercising the router's err output.
- Not defined: no inj_err port; the parity byte is always correct.

Test Plan:
1. addr=1, len=3, payload 11,22,33, busy=0 -> stream 0D,11,22,33 with pkt_valid=1, then 0D with pkt_valid=0; tx_done one pulse; cmd_ready returns after 2 GAP cycles.
2. Same packet, busy=1 for 3 cycles while data_out=22 -> 22 held with pkt_valid=1 for 4 cycles total; following bytes unchanged; parity 0D.
3. start with addr=3, then start with len=0 -> cmd_err pulses each time; pl_ready and pkt_valid stay 0; cmd_ready stays 1.
4. addr=2, len=63, payload 00..3E -> header FE, 63 payload bytes in order, parity C1 with pkt_valid=0.
5. reset asserted during PAY (e.g. third byte) -> next cycle pkt_valid=0, data_out=0, cmd_ready=1; a new packet then streams correctly with a fresh parity.
6. LOAD with pl_valid toggling 1,0,0,1,1 for len=3 -> no router activity until the third byte is accepted; header appears the next cycle.
